// File: rtl/sr04_pkg.sv
// sr04_pkg: HC-SR04 timing defaults shared with distance_calculator,
// plus the trigger controller state encoding.
package sr04_pkg;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_TRIG_US      = 10;
    localparam int DEF_ECHO_WAIT_US = 30000;
    localparam int DEF_ECHO_MAX_US  = 25000;
    localparam int DEF_PERIOD_US    = 60000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_ECHO_HIGH = 3'd3,
        S_HOLDOFF   = 3'd4
    } sr04_state_t;

endpackage

// File: rtl/sr04_echo_sync.sv
// sr04_echo_sync: two-flop synchroniser for the raw echo pin with
// single-cycle rise/fall strobes taken from the synchronised level.
module sr04_echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_echo,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/sr04_trigger_ctrl.sv
// sr04_trigger_ctrl: HC-SR04 initiator - trigger pulse, echo supervision
// with timeouts, and a minimum trigger-to-trigger measurement period.
module sr04_trigger_ctrl
    import sr04_pkg::*;
#(
    parameter int TRIG_US      = DEF_TRIG_US,
    parameter int ECHO_WAIT_US = DEF_ECHO_WAIT_US,
    parameter int ECHO_MAX_US  = DEF_ECHO_MAX_US,
    parameter int PERIOD_US    = DEF_PERIOD_US,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             start,
    input  logic             auto_mode,
    input  logic             echo,
    output logic             trigger,
    output logic             echo_sync,
    output logic             busy,
    output logic             meas_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] echo_us
);

    localparam logic [CNT_W-1:0] L_TRIG = CNT_W'(TRIG_US);
    localparam logic [CNT_W-1:0] L_WAIT = CNT_W'(ECHO_WAIT_US - 1);
    localparam logic [CNT_W-1:0] L_EMAX = CNT_W'(ECHO_MAX_US - 1);
    localparam logic [CNT_W-1:0] L_PER  = CNT_W'(PERIOD_US - 1);

    sr04_state_t      r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [CNT_W-1:0] r_per, w_per_nx, w_per_inc;
    logic [CNT_W-1:0] r_echo_us, w_echo_us_nx;
    logic             r_trig, w_trig_nx;
    logic             r_busy;
    logic             r_valid, w_valid_nx;
    logic             r_to, w_to_nx;
    logic             w_rise, w_fall, w_go;
    logic             w_trig_done, w_wait_to, w_echo_to, w_per_done;

    sr04_echo_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_echo (echo),
        .o_sync (echo_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_go        = start | auto_mode;
    assign w_cnt_inc   = i_tick ? r_cnt + 1'b1 : r_cnt;
    // Period counter saturates so an oversized PERIOD_US cannot wrap it.
    assign w_per_inc   = (i_tick && r_per != '1) ? r_per + 1'b1 : r_per;
    assign w_trig_done = i_tick && (r_cnt == L_TRIG);
    assign w_wait_to   = i_tick && (r_cnt == L_WAIT);
    assign w_echo_to   = i_tick && (r_cnt == L_EMAX);
    assign w_per_done  = i_tick && (r_per >= L_PER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_per     <= '0;
            r_echo_us <= '0;
            r_trig    <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_per     <= w_per_nx;
            r_echo_us <= w_echo_us_nx;
            r_trig    <= w_trig_nx;
            r_busy    <= (w_state_nx != S_IDLE);
            r_valid   <= w_valid_nx;
            r_to      <= w_to_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:      if (w_go) w_state_nx = S_TRIG;
            S_TRIG:      if (w_trig_done) w_state_nx = S_WAIT_ECHO;
            S_WAIT_ECHO: begin
                if (w_rise)         w_state_nx = S_ECHO_HIGH;
                else if (w_wait_to) w_state_nx = S_HOLDOFF;
            end
            S_ECHO_HIGH: if (w_fall || w_echo_to) w_state_nx = S_HOLDOFF;
            S_HOLDOFF:   if (w_per_done) w_state_nx = S_IDLE;
            default:     w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nx     = r_cnt;
        w_per_nx     = r_per;
        w_echo_us_nx = r_echo_us;
        w_trig_nx    = r_trig;
        w_valid_nx   = 1'b0;
        w_to_nx      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_trig_nx = 1'b1;
                    w_cnt_nx  = '0;
                    w_per_nx  = '0;
                end
            end
            S_TRIG: begin
                w_cnt_nx = w_cnt_inc;
                w_per_nx = w_per_inc;
                if (w_trig_done) begin
                    w_trig_nx = 1'b0;
                    w_cnt_nx  = '0;
                end
            end
            S_WAIT_ECHO: begin
                w_cnt_nx = w_cnt_inc;
                w_per_nx = w_per_inc;
                // An edge in the same cycle as the timeout tick wins.
                if (w_rise)         w_cnt_nx = '0;
                else if (w_wait_to) w_to_nx  = 1'b1;
            end
            S_ECHO_HIGH: begin
                w_cnt_nx = w_cnt_inc;
                w_per_nx = w_per_inc;
                if (w_fall) begin
                    w_echo_us_nx = r_cnt;
                    w_valid_nx   = 1'b1;
                end else if (w_echo_to) begin
                    w_to_nx = 1'b1;
                end
            end
            S_HOLDOFF: w_per_nx = w_per_inc;
            default: ;
        endcase
    end

    assign trigger    = r_trig;
    assign busy       = r_busy;
    assign meas_valid = r_valid;
    assign timeout    = r_to;
    assign echo_us    = r_echo_us;

endmodule

// File: tb/tb_sr04_trigger_ctrl.sv
// tb_sr04_trigger_ctrl: table-driven single shots with an event scoreboard,
// plus auto-mode, start-spam and mid-measurement reset sequences.
module tb_sr04_trigger_ctrl;

    localparam int TDIV = 5;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_tick;
    logic          start;
    logic          auto_mode;
    logic          echo;
    logic          trigger;
    logic          echo_sync;
    logic          busy;
    logic          meas_valid;
    logic          timeout;
    logic [CW-1:0] echo_us;

    typedef struct {
        bit to;
        int w;
        int lat;
    } exp_t;

    typedef struct {
        int dly;
        int wid;
        bit to;
        int w;
        int lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    int   n_tests    = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   t_fall     = 0;
    int   last_w     = 0;
    int   trig_rises = 0;
    logic trig_q     = 1'b0;

    sr04_trigger_ctrl #(
        .TRIG_US      (10),
        .ECHO_WAIT_US (300),
        .ECHO_MAX_US  (250),
        .PERIOD_US    (600),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (i_tick),
        .start      (start),
        .auto_mode  (auto_mode),
        .echo       (echo),
        .trigger    (trigger),
        .echo_sync  (echo_sync),
        .busy       (busy),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .echo_us    (echo_us)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        i_tick = 1'b0;
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            i_tick = 1'b1;
            @(negedge clk);
            i_tick = 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // sel 0 watches trigger, sel 1 watches busy; call at a negedge.
    task automatic wait_lvl(input int sel, input logic lvl,
                            input int maxc, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (((sel == 0) ? trigger : busy) == lvl) ok = 1'b1;
            else @(negedge clk);
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic echo_pulse(input int dly_us, input int wid_us);
        repeat (dly_us * TDIV) @(negedge clk);
        echo = 1'b1;
        repeat (wid_us * TDIV) @(negedge clk);
        echo = 1'b0;
    endtask

    task automatic run_meas(input vec_t v);
        int t_rise;
        sb.push_back('{v.to, v.w, v.lat});
        pulse_start();
        wait_lvl(0, 1'b1, 5, "trig_rise_wait");
        t_rise = cyc;
        wait_lvl(0, 1'b0, 100, "trig_fall_wait");
        chk_rng("trig_width_cyc", cyc - t_rise, 51, 55);
        t_fall = cyc;
        if (v.wid > 0) echo_pulse(v.dly, v.wid);
        wait_lvl(1, 1'b0, 4000, "busy_fall_wait");
        chk_rng("busy_width_cyc", cyc - t_rise, 2996, 3000);
        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            trig_q = 1'b0;
        end else begin
            if (trigger && !trig_q) trig_rises++;
            trig_q = trigger;
            if (meas_valid || timeout) begin
                chk("valid_timeout_excl", int'(meas_valid & timeout), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_event", int'({meas_valid, timeout}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_timeout", int'(timeout), int'(e.to));
                    if (e.to) begin
                        chk_rng("echo_us_hold", int'(echo_us),
                                last_w - 1, last_w + 1);
                    end else begin
                        chk_rng("echo_us", int'(echo_us), e.w - 1, e.w + 1);
                        last_w = e.w;
                    end
                    if (e.lat > 0)
                        chk_rng("event_latency_us", (cyc - t_fall) / TDIV,
                                e.lat - 2, e.lat + 2);
                end
            end
        end
    end

    initial begin
        int n;
        int r[3];

        rst       = 1'b1;
        start     = 1'b0;
        auto_mode = 1'b0;
        echo      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_echo_sync", int'(echo_sync), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_echo_us", int'(echo_us), 0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{20, 116, 1'b0, 116, 0};
        vecs[1] = '{0, 30, 1'b0, 30, 0};
        vecs[2] = '{295, 50, 1'b0, 50, 0};
        vecs[3] = '{20, 245, 1'b0, 245, 0};
        vecs[4] = '{20, 0, 1'b1, 0, 300};
        vecs[5] = '{305, 50, 1'b1, 0, 300};
        vecs[6] = '{20, 255, 1'b1, 0, 270};
        vecs[7] = '{20, 400, 1'b1, 0, 270};
        for (int i = 0; i < 8; i++) run_meas(vecs[i]);

        auto_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{1'b0, 58, 0});
            wait_lvl(0, 1'b1, 3200, "auto_rise_wait");
            r[i] = cyc;
            if (i == 2) auto_mode = 1'b0;
            wait_lvl(0, 1'b0, 100, "auto_fall_wait");
            echo_pulse(20, 58);
        end
        wait_lvl(1, 1'b0, 4000, "auto_busy_fall");
        chk_rng("auto_period_first", r[1] - r[0], 2997, 3001);
        chk("auto_period_steady", r[2] - r[1], 3000);
        n = trig_rises;
        repeat (100 * TDIV) @(negedge clk);
        chk("auto_stops", trig_rises - n, 0);
        chk("auto_idle_busy", int'(busy), 0);
        chk("auto_sb_drained", sb.size(), 0);

        n = trig_rises;
        sb.push_back('{1'b0, 58, 0});
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    pulse_start();
                    repeat (50 * TDIV - 2) @(negedge clk);
                end
            end
            begin
                wait_lvl(0, 1'b1, 10, "spam_rise_wait");
                wait_lvl(0, 1'b0, 100, "spam_fall_wait");
                echo_pulse(20, 58);
            end
        join
        wait_lvl(1, 1'b0, 1000, "spam_busy_fall");
        repeat (5) @(negedge clk);
        chk("spam_one_trigger", trig_rises - n, 1);
        chk("spam_sb_drained", sb.size(), 0);

        pulse_start();
        wait_lvl(0, 1'b1, 5, "rst1_rise_wait");
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_trig_trigger", int'(trigger), 0);
        chk("rst_trig_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        pulse_start();
        wait_lvl(0, 1'b1, 5, "rst2_rise_wait");
        wait_lvl(0, 1'b0, 100, "rst2_fall_wait");
        repeat (20 * TDIV) @(negedge clk);
        echo = 1'b1;
        repeat (50 * TDIV) @(negedge clk);
        chk("echo_sync_high", int'(echo_sync), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_echo_echo_sync", int'(echo_sync), 0);
        chk("rst_echo_busy", int'(busy), 0);
        chk("rst_echo_trigger", int'(trigger), 0);
        @(negedge clk);
        chk("rst_echo_echo_us", int'(echo_us), 0);
        echo = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        last_w = 0;
        @(negedge clk);
        run_meas('{20, 116, 1'b0, 116, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        n_fail++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
